usb_tx_bit_encoder: RTL and testbench



---
 rtl/usb_tx_bit_encoder.sv | 229 ++++++++++++++++++++++
 tb/tb_usb_tx_bit_encoder.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_bit_encoder.sv
// rtl/usb_tx_bit_encoder.sv - full-speed USB TX line encoder: SYNC, LSB-first serializer, bit stuffing, NRZI, EOP
// Consumes the packet loader's byte stream and drives registered D+/D- once per bit_en strobe.
module usb_tx_bit_encoder #(
  parameter int STUFF_LEN    = 6,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       dp,
  output logic       dm,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int OW      = $clog2(STUFF_LEN + 1);
  localparam int CNT_MAX = (EOP_SE0_BITS > 8) ? EOP_SE0_BITS : 8;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    bit_cnt;
  logic [2:0]    bit_cnt_n;
  logic [OW-1:0] ones;
  logic [OW-1:0] ones_n;
  logic [7:0]    shifter;
  logic [7:0]    shifter_n;
  logic          cur_last;
  logic          cur_last_n;
  logic [7:0]    hold_data;
  logic          hold_full;
  logic          hold_last;
  logic          last_seen;
  logic          dp_n;
  logic          dm_n;
  logic          active_n;
  logic          done_n;
  logic          err_n;
  logic          accept;
  logic          load;
  logic          advance;
  logic          send;
  logic          send_bit;
  logic          se0;
  logic          drive_j;

  assign tx_ready = !hold_full && !last_seen;
  assign accept   = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_cnt   <= '0;
      ones      <= '0;
      shifter   <= '0;
      cur_last  <= 1'b0;
      hold_data <= '0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      last_seen <= 1'b0;
      dp        <= 1'b1;
      dm        <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_err    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_cnt   <= bit_cnt_n;
      ones      <= ones_n;
      shifter   <= shifter_n;
      cur_last  <= cur_last_n;
      dp        <= dp_n;
      dm        <= dm_n;
      tx_active <= active_n;
      tx_done   <= done_n;
      tx_err    <= err_n;
      if (load) begin
        hold_full <= 1'b0;
      end
      // A byte accepted on the same edge as a transfer lands in the freshly emptied hold register.
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= tx_data;
        hold_last <= tx_last;
        if (tx_last) begin
          last_seen <= 1'b1;
        end
      end
      if (done_n) begin
        last_seen <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    bit_cnt_n  = bit_cnt;
    ones_n     = ones;
    shifter_n  = shifter;
    cur_last_n = cur_last;
    active_n   = tx_active;
    done_n     = 1'b0;
    err_n      = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    send       = 1'b0;
    send_bit   = 1'b0;
    se0        = 1'b0;
    drive_j    = 1'b0;

    if (bit_en) begin
      case (state)
        IDLE: begin
          if (hold_full) begin
            // bit_cnt=7 and cur_last=0 make the SYNC end look like a normal byte boundary.
            state_n    = SYNC;
            active_n   = 1'b1;
            cnt_n      = CW'(1);
            bit_cnt_n  = 3'd7;
            cur_last_n = 1'b0;
            send       = 1'b1;
            send_bit   = 1'b0;
          end
        end
        SYNC: begin
          if (cnt < CW'(8)) begin
            send     = 1'b1;
            send_bit = (cnt == CW'(7));
            cnt_n    = cnt + CW'(1);
          end else begin
            advance = 1'b1;
          end
        end
        DATA, STUFF: begin
          advance = 1'b1;
        end
        EOP_SE0: begin
          if (cnt < CW'(EOP_SE0_BITS)) begin
            se0   = 1'b1;
            cnt_n = cnt + CW'(1);
          end else begin
            state_n = EOP_J;
            drive_j = 1'b1;
          end
        end
        EOP_J: begin
          state_n  = IDLE;
          active_n = 1'b0;
          done_n   = 1'b1;
          drive_j  = 1'b1;
        end
        default: begin
          state_n = IDLE;
        end
      endcase

      if (advance) begin
        if (ones == OW'(STUFF_LEN)) begin
          state_n  = STUFF;
          send     = 1'b1;
          send_bit = 1'b0;
        end else if (bit_cnt != 3'd7) begin
          state_n   = DATA;
          bit_cnt_n = bit_cnt + 3'd1;
          shifter_n = shifter >> 1;
          send      = 1'b1;
          send_bit  = shifter[1];
        end else if (cur_last) begin
          state_n = EOP_SE0;
          se0     = 1'b1;
          cnt_n   = CW'(1);
        end else if (hold_full) begin
          state_n    = DATA;
          load       = 1'b1;
          shifter_n  = hold_data;
          cur_last_n = hold_last;
          bit_cnt_n  = 3'd0;
          send       = 1'b1;
          send_bit   = hold_data[0];
        end else begin
          state_n = EOP_SE0;
          err_n   = 1'b1;
          se0     = 1'b1;
          cnt_n   = CW'(1);
        end
      end
    end

    if (send) begin
      ones_n = send_bit ? (ones + OW'(1)) : '0;
    end

    // NRZI: a 0 swaps J and K, a 1 holds the line.
    dp_n = dp;
    dm_n = dm;
    if (send && !send_bit) begin
      dp_n = dm;
      dm_n = dp;
    end
    if (se0) begin
      dp_n = 1'b0;
      dm_n = 1'b0;
    end
    if (drive_j) begin
      dp_n = 1'b1;
      dm_n = 1'b0;
    end
  end

endmodule

// File: tb/tb_usb_tx_bit_encoder.sv
// tb/tb_usb_tx_bit_encoder.sv - directed bench for usb_tx_bit_encoder with line decoder and byte scoreboard
module tb_usb_tx_bit_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       dp;
  logic       dm;
  logic       tx_active;
  logic       tx_done;
  logic       tx_err;

  int checks   = 0;
  int failures = 0;

  logic [8:0] feed_q[$];
  logic [7:0] exp_q[$];
  logic [1:0] sym_log[$];
  int         stuff_pos[$];

  logic [1:0] prev_sym;
  logic [7:0] sync_shift;
  logic [7:0] byte_sh;
  int         pkt_bits;
  int         data_bits;
  int         nb;
  int         run;
  int         max_run;
  int         stuffs;
  int         active_clks;
  int         active_bits;
  int         done_cnt;
  int         err_cnt;
  logic [1:0] err_sym;
  int         bp_cycles;
  int         ready_viol;
  logic       after_last;

  usb_tx_bit_encoder #(.STUFF_LEN(6), .EOP_SE0_BITS(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .dp        (dp),
    .dm        (dm),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_err    (tx_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sym_ch(input logic [1:0] s);
    case (s)
      2'b10:   return "J";
      2'b01:   return "K";
      2'b00:   return "S";
      default: return "X";
    endcase
  endfunction

  task automatic start_test();
    sym_log.delete();
    stuff_pos.delete();
    prev_sym    = 2'b10;
    sync_shift  = '0;
    byte_sh     = '0;
    pkt_bits    = 0;
    data_bits   = 0;
    nb          = 0;
    run         = 0;
    max_run     = 0;
    stuffs      = 0;
    active_clks = 0;
    active_bits = 0;
    done_cnt    = 0;
    err_cnt     = 0;
    err_sym     = 2'b11;
    bp_cycles   = 0;
    ready_viol  = 0;
    after_last  = 1'b0;
  endtask

  // NRZI decode, destuff and reassemble LSB-first bytes, comparing each against the scoreboard.
  task automatic dec_edge(input logic [1:0] sym);
    logic b;
    logic [7:0] e;
    sym_log.push_back(sym);
    if (sym != 2'b00 && prev_sym != 2'b00) begin
      b = (sym == prev_sym);
      pkt_bits++;
      if (pkt_bits <= 8) begin
        sync_shift = {b, sync_shift[7:1]};
      end else if (run == 6) begin
        stuffs++;
        stuff_pos.push_back(data_bits);
        check("stuff_bit_zero", {31'd0, b}, 32'd0);
      end else begin
        data_bits++;
        byte_sh = {b, byte_sh[7:1]};
        nb++;
        if (nb == 8) begin
          nb = 0;
          check("scoreboard_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("decoded_byte", {24'd0, byte_sh}, {24'd0, e});
          end
        end
      end
      run = b ? run + 1 : 0;
      if (run > max_run) max_run = run;
    end
    prev_sym = sym;
  endtask

  task automatic clk_cycle(input logic be);
    logic acc;
    @(negedge clk);
    bit_en = be;
    if (feed_q.size() != 0) begin
      tx_valid = 1'b1;
      tx_data  = feed_q[0][7:0];
      tx_last  = feed_q[0][8];
    end else begin
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      tx_last  = 1'b0;
    end
    #1;
    acc = tx_valid && tx_ready;
    if (tx_valid && !tx_ready) bp_cycles++;
    if (after_last && tx_ready) ready_viol++;
    @(posedge clk);
    #1;
    if (acc) begin
      if (feed_q[0][8]) after_last = 1'b1;
      void'(feed_q.pop_front());
    end
    if (tx_active) active_clks++;
    if (tx_done) begin
      done_cnt++;
      after_last = 1'b0;
    end
    if (tx_err) begin
      err_cnt++;
      err_sym = {dp, dm};
    end
    if (be && tx_active) begin
      active_bits++;
      dec_edge({dp, dm});
    end
  endtask

  task automatic bit_period();
    clk_cycle(1'b1);
    repeat (3) clk_cycle(1'b0);
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    feed_q.push_back({last, d});
    exp_q.push_back(d);
  endtask

  task automatic wait_done(input int max_bits);
    int n;
    n = 0;
    while (done_cnt == 0 && n < max_bits) begin
      bit_period();
      n++;
    end
    check("done_within_budget", {31'd0, done_cnt != 0}, 32'd1);
    repeat (2) bit_period();
  endtask

  initial begin
    string exp_s;
    int    n;

    rst      = 1'b1;
    bit_en   = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    start_test();

    // Reset
    clk_cycle(1'b0);
    clk_cycle(1'b1);
    check("rst_dp", {31'd0, dp}, 32'd1);
    check("rst_dm", {31'd0, dm}, 32'd0);
    check("rst_active", {31'd0, tx_active}, 32'd0);
    check("rst_done", {31'd0, tx_done}, 32'd0);
    check("rst_err", {31'd0, tx_err}, 32'd0);
    rst = 1'b0;
    clk_cycle(1'b0);
    check("rst_ready_after_release", {31'd0, tx_ready}, 32'd1);

    // Single 0x00 with last
    start_test();
    push_byte(8'h00, 1'b1);
    wait_done(60);
    exp_s = "KJKJKJKKJKJKJKJKSSJ";
    check("b00_sym_count", sym_log.size(), 32'd19);
    for (int i = 0; i < 19 && i < sym_log.size(); i++) begin
      check($sformatf("b00_sym%0d", i), {24'd0, sym_ch(sym_log[i])}, {24'd0, exp_s[i]});
    end
    check("b00_sync", {24'd0, sync_shift}, 32'h80);
    check("b00_done_cnt", done_cnt, 32'd1);
    check("b00_active_bits", active_bits, 32'd19);
    check("b00_active_clks", active_clks, 32'd76);
    check("b00_err_cnt", err_cnt, 32'd0);
    check("b00_sb_empty", exp_q.size(), 32'd0);

    // 0xFF, 0xFF: stuffing
    start_test();
    push_byte(8'hFF, 1'b0);
    push_byte(8'hFF, 1'b1);
    wait_done(80);
    check("ff_stuffs", stuffs, 32'd2);
    check("ff_stuff_pos_n", stuff_pos.size(), 32'd2);
    if (stuff_pos.size() == 2) begin
      check("ff_stuff_pos0", stuff_pos[0], 32'd5);
      check("ff_stuff_pos1", stuff_pos[1], 32'd11);
    end
    check("ff_bits_to_eop", pkt_bits, 32'd26);
    check("ff_max_run", max_run, 32'd6);
    check("ff_sync", {24'd0, sync_shift}, 32'h80);
    check("ff_done_cnt", done_cnt, 32'd1);
    check("ff_sb_empty", exp_q.size(), 32'd0);

    // Back-pressure
    start_test();
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b0);
    push_byte(8'h0F, 1'b1);
    wait_done(100);
    check("bp_ready_dropped", {31'd0, bp_cycles != 0}, 32'd1);
    check("bp_ready_after_last", ready_viol, 32'd0);
    check("bp_data_bits", data_bits, 32'd24);
    check("bp_stuffs", stuffs, 32'd0);
    check("bp_done_cnt", done_cnt, 32'd1);
    check("bp_sb_empty", exp_q.size(), 32'd0);

    // Underrun
    start_test();
    push_byte(8'h12, 1'b0);
    wait_done(60);
    check("ur_err_cnt", err_cnt, 32'd1);
    check("ur_err_on_se0", {30'd0, err_sym}, 32'd0);
    check("ur_sym_count", sym_log.size(), 32'd19);
    if (sym_log.size() == 19) begin
      check("ur_eop0", {24'd0, sym_ch(sym_log[16])}, 32'h53);
      check("ur_eop1", {24'd0, sym_ch(sym_log[17])}, 32'h53);
      check("ur_eop2", {24'd0, sym_ch(sym_log[18])}, 32'h4A);
    end
    check("ur_done_cnt", done_cnt, 32'd1);
    check("ur_sb_empty", exp_q.size(), 32'd0);

    // Reset in the middle of 0x55, with bit_en on the same edge
    start_test();
    push_byte(8'h55, 1'b1);
    n = 0;
    while (active_bits < 11 && n < 40) begin
      bit_period();
      n++;
    end
    check("mr_reached_mid_byte", active_bits, 32'd11);
    rst = 1'b1;
    clk_cycle(1'b1);
    check("mr_dp", {31'd0, dp}, 32'd1);
    check("mr_dm", {31'd0, dm}, 32'd0);
    check("mr_active", {31'd0, tx_active}, 32'd0);
    check("mr_ready", {31'd0, tx_ready}, 32'd1);
    check("mr_done", {31'd0, tx_done}, 32'd0);
    check("mr_err", {31'd0, tx_err}, 32'd0);
    rst = 1'b0;
    after_last = 1'b0;
    repeat (4) bit_period();
    check("mr_no_done", done_cnt, 32'd0);
    check("mr_no_err", err_cnt, 32'd0);
    check("mr_idle_active", {31'd0, tx_active}, 32'd0);

    exp_q.delete();
    start_test();
    push_byte(8'h55, 1'b1);
    wait_done(60);
    check("mr2_data_bits", data_bits, 32'd8);
    check("mr2_sym_count", sym_log.size(), 32'd19);
    check("mr2_done_cnt", done_cnt, 32'd1);
    check("mr2_err_cnt", err_cnt, 32'd0);
    check("mr2_sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
